// File: rtl/p_flags_pkg.sv
// Shared definitions for the 6502 processor status register stage.
package p_flags_pkg;

  // Bit positions of each flag inside the packed P image.
  localparam int P_C = 0;
  localparam int P_Z = 1;
  localparam int P_I = 2;
  localparam int P_D = 3;
  localparam int P_B = 4;
  localparam int P_U = 5;
  localparam int P_V = 6;
  localparam int P_N = 7;

  // Image after reset (I set, bit 5 set, B set); the flag reset values are taken from it.
  localparam logic [7:0] P_RESET = 8'h34;

endpackage

// File: rtl/so_edge_det.sv
// SO pin synchroniser with falling-edge detection; emits a one-cycle so_edge pulse.
module so_edge_det (
  input  logic PHI2,
  input  logic n_RES,
  input  logic SO,
  output logic so_edge
);

  logic so_s1;
  logic so_s2;
  logic so_s3;

  // Two-flop synchroniser followed by a history flop; every stage resets high, so no edge is pending after reset.
  always_ff @(posedge PHI2 or negedge n_RES) begin
    if (!n_RES) begin
      so_s1 <= 1'b1;
      so_s2 <= 1'b1;
      so_s3 <= 1'b1;
    end else begin
      so_s1 <= SO;
      so_s2 <= so_s1;
      so_s3 <= so_s2;
    end
  end

  // Falling edge: the synchronised value is now low but was high one cycle earlier.
  assign so_edge = ~so_s2 & so_s3;

endmodule

// File: rtl/p_flags.sv
// 6502 P register: flag capture from ALU and DB, packed image drive onto DB, SO set-overflow.
module p_flags
  import p_flags_pkg::*;
(
  input  logic       PHI2,
  input  logic       n_RES,
  inout  wire  [7:0] DB,
  input  logic       ACR,
  input  logic       AVR,
  input  logic       DB_P,
  input  logic       DBZ_Z,
  input  logic       DB_N,
  input  logic       DB_V,
  input  logic       ACR_C,
  input  logic       AVR_V,
  input  logic       IR5,
  input  logic       IR5_C,
  input  logic       IR5_I,
  input  logic       IR5_D,
  input  logic       Z_V,
  input  logic       SET_I,
  input  logic       P_DB,
  input  logic       B_HW,
  input  logic       SO,
  output logic       C_OUT,
  output logic       Z_OUT,
  output logic       I_OUT,
  output logic       D_OUT,
  output logic       V_OUT,
  output logic       N_OUT
);

  logic c_q, z_q, i_q, d_q, v_q, n_q;
  logic c_d, z_d, i_d, d_d, v_d, n_d;
  logic so_edge;
  logic db_zero;
  logic [7:0] p_img;

  so_edge_det u_so_edge_det (
    .PHI2    (PHI2),
    .n_RES   (n_RES),
    .SO      (SO),
    .so_edge (so_edge)
  );

  assign db_zero = (DB == 8'h00);

  // Packed image for pushes; B reads 0 only for hardware interrupt pushes, bit 5 is always 1.
  always_comb begin
    p_img      = 8'h00;
    p_img[P_C] = c_q;
    p_img[P_Z] = z_q;
    p_img[P_I] = i_q;
    p_img[P_D] = d_q;
    p_img[P_B] = ~B_HW;
    p_img[P_U] = 1'b1;
    p_img[P_V] = v_q;
    p_img[P_N] = n_q;
  end

  // Output enable follows P_DB directly; DB floats otherwise.
  assign DB = P_DB ? p_img : 8'hzz;

  // Per-flag priority muxes; DB loads see the pre-edge bus, so P_DB with DB_P reloads the same value.
  always_comb begin
    c_d = c_q;
    z_d = z_q;
    i_d = i_q;
    d_d = d_q;
    v_d = v_q;
    n_d = n_q;

    if (DB_P)       c_d = DB[P_C];
    else if (ACR_C) c_d = ACR;
    else if (IR5_C) c_d = IR5;

    if (DB_P)       z_d = DB[P_Z];
    else if (DBZ_Z) z_d = db_zero;

    if (DB_P)       n_d = DB[P_N];
    else if (DB_N)  n_d = DB[P_N];

    if (DB_P)       i_d = DB[P_I];
    else if (SET_I) i_d = 1'b1;
    else if (IR5_I) i_d = IR5;

    if (DB_P)       d_d = DB[P_D];
    else if (IR5_D) d_d = IR5;

    // The SO edge overrides every other overflow source.
    if (so_edge)    v_d = 1'b1;
    else if (DB_P)  v_d = DB[P_V];
    else if (AVR_V) v_d = AVR;
    else if (DB_V)  v_d = DB[P_V];
    else if (Z_V)   v_d = 1'b0;
  end

  // Flag registers; reset values come from the reset image.
  always_ff @(posedge PHI2 or negedge n_RES) begin
    if (!n_RES) begin
      c_q <= P_RESET[P_C];
      z_q <= P_RESET[P_Z];
      i_q <= P_RESET[P_I];
      d_q <= P_RESET[P_D];
      v_q <= P_RESET[P_V];
      n_q <= P_RESET[P_N];
    end else begin
      c_q <= c_d;
      z_q <= z_d;
      i_q <= i_d;
      d_q <= d_d;
      v_q <= v_d;
      n_q <= n_d;
    end
  end

  assign C_OUT = c_q;
  assign Z_OUT = z_q;
  assign I_OUT = i_q;
  assign D_OUT = d_q;
  assign V_OUT = v_q;
  assign N_OUT = n_q;

endmodule
